// File: rtl/calc_axil_core.sv
// -----------------------------------------------------------------------------
// calc_axil_core
//
// AXI4-Lite slave wrapping a small arithmetic/logic engine.
//
// Register map (index k lives at byte address k * DATA_WIDTH/8):
//   0 OPA       rw   first operand
//   1 OPB       rw   second operand
//   2 CTRL      rw   [2:0] op, [8] START (write-1 pulse, reads 0), [9] irq_en
//   3 STATUS    ro   [0] busy, [1] done, [2] err, [3] overrun
//   4 RESULT_LO ro
//   5 RESULT_HI ro
//   6-7         unmapped (SLVERR, reads 0)
//
// Ports:
//   ACLK, ARESET          clock (rising edge), asynchronous active-high reset
//   S_AXI_AW*/W*/B*       AXI4-Lite write address / data / response channels
//   S_AXI_AR*/R*          AXI4-Lite read address / data channels
//   IRQ                   level interrupt, STATUS.done AND CTRL.irq_en
//
// The engine is a three-state FSM (IDLE, RUN, FINISH). Operands and opcode are
// snapshotted on START, so host writes during a run never disturb it.
// Multiplication is an iterative shift-add taking DATA_WIDTH RUN cycles.
// -----------------------------------------------------------------------------
module calc_axil_core #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            IRQ
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = (DW == 64) ? 3 : 2;
    localparam int CW       = $clog2(DW);

    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [2:0] IDX_OPA    = 3'd0;
    localparam logic [2:0] IDX_OPB    = 3'd1;
    localparam logic [2:0] IDX_CTRL   = 3'd2;
    localparam logic [2:0] IDX_STATUS = 3'd3;
    localparam logic [2:0] IDX_RES_LO = 3'd4;
    localparam logic [2:0] IDX_RES_HI = 3'd5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Merge new data into an existing register honouring byte strobes.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [NB-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // ---------------------------------------------------------------- state
    logic          aw_held_q, aw_held_d;
    logic [2:0]    aw_idx_q, aw_idx_d;
    logic          w_held_q, w_held_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [NB-1:0] w_strb_q, w_strb_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;

    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;

    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [2:0]    op_q, op_d;
    logic          irq_en_q, irq_en_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          overrun_q, overrun_d;
    logic [DW-1:0] res_lo_q, res_lo_d;
    logic [DW-1:0] res_hi_q, res_hi_d;
    logic          irq_q, irq_d;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   snap_a_q, snap_a_d;
    logic [DW-1:0]   snap_b_q, snap_b_d;
    logic [2:0]      snap_op_q, snap_op_d;
    logic [2*DW-1:0] prod_q, prod_d;

    // ------------------------------------------------------- combinational
    logic          aw_hs_s, w_hs_s, commit_s, wr_start_s;
    logic          ar_hs_s;
    logic [2:0]    ar_idx_s;
    logic [DW-1:0] rd_val_s;
    logic          run_last_s;
    logic          eng_busy_s, eng_load_s, res_we_s, eng_fin_s;
    logic [DW:0]   add_s, sub_s, mul_sum_s;
    logic [2*DW-1:0] prod_step_s;
    logic [DW-1:0] alu_lo_s, alu_hi_s;
    logic          alu_err_s;
    logic          unused_s;

    assign S_AXI_AWREADY = ~aw_held_q & ~bvalid_q;
    assign S_AXI_WREADY  = ~w_held_q & ~bvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ~rvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign IRQ           = irq_q;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    assign aw_hs_s  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs_s   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs_s  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign ar_idx_s = S_AXI_ARADDR[ADDR_LSB+2:ADDR_LSB];

    // A write lands in the cycle both halves are held.
    assign commit_s   = aw_held_q & w_held_q;
    assign wr_start_s = commit_s & (aw_idx_q == IDX_CTRL) & w_strb_q[1] & w_data_q[8];

    // Non-multiply ops finish after a single RUN cycle.
    assign run_last_s = (snap_op_q != OP_MUL) | (cnt_q == CNT_LAST);

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole accumulator right. The multiplier starts in
    // the lower half and is consumed LSB first.
    assign mul_sum_s   = {1'b0, prod_q[2*DW-1:DW]}
                       + (prod_q[0] ? {1'b0, snap_a_q} : {(DW+1){1'b0}});
    assign prod_step_s = {mul_sum_s, prod_q[DW-1:1]};

    assign add_s = {1'b0, snap_a_q} + {1'b0, snap_b_q};
    assign sub_s = {1'b0, snap_a_q} - {1'b0, snap_b_q};

    // Engine state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Engine next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_start_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (run_last_s) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Engine output decode
    always_comb begin
        eng_busy_s = 1'b0;
        eng_load_s = 1'b0;
        res_we_s   = 1'b0;
        eng_fin_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                eng_load_s = wr_start_s;
            end
            ST_RUN: begin
                eng_busy_s = 1'b1;
                res_we_s   = run_last_s;
            end
            ST_FINISH: begin
                eng_busy_s = 1'b1;
                eng_fin_s  = 1'b1;
            end
            default: begin
                eng_busy_s = 1'b0;
            end
        endcase
    end

    // Result selection for the snapshotted opcode
    always_comb begin
        alu_lo_s  = {DW{1'b0}};
        alu_hi_s  = {DW{1'b0}};
        alu_err_s = 1'b0;
        case (snap_op_q)
            OP_ADD: begin
                alu_lo_s = add_s[DW-1:0];
                alu_hi_s = {{(DW-1){1'b0}}, add_s[DW]};
            end
            OP_SUB: begin
                // Bit DW of the widened difference is the borrow.
                alu_lo_s = sub_s[DW-1:0];
                alu_hi_s = {{(DW-1){1'b0}}, sub_s[DW]};
            end
            OP_MUL: begin
                alu_lo_s = prod_step_s[DW-1:0];
                alu_hi_s = prod_step_s[2*DW-1:DW];
            end
            OP_AND: alu_lo_s = snap_a_q & snap_b_q;
            OP_OR:  alu_lo_s = snap_a_q | snap_b_q;
            OP_XOR: alu_lo_s = snap_a_q ^ snap_b_q;
            default: begin
                alu_err_s = 1'b1;
            end
        endcase
    end

    // Write address/data capture and write response
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (commit_s) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (aw_idx_q > IDX_RES_HI) ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (aw_hs_s) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[ADDR_LSB+2:ADDR_LSB];
            end else begin
                aw_held_d = aw_held_q;
            end
            if (w_hs_s) begin
                w_held_d = 1'b1;
                w_data_d = S_AXI_WDATA;
                w_strb_d = S_AXI_WSTRB;
            end else begin
                w_held_d = w_held_q;
            end
            if (bvalid_q && S_AXI_BREADY) begin
                bvalid_d = 1'b0;
            end else begin
                bvalid_d = bvalid_q;
            end
        end
    end

    // Register file, status flags and engine datapath
    always_comb begin
        opa_d     = opa_q;
        opb_d     = opb_q;
        op_d      = op_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        cnt_d     = cnt_q;
        snap_a_d  = snap_a_q;
        snap_b_d  = snap_b_q;
        snap_op_d = snap_op_q;
        prod_d    = prod_q;

        if (commit_s) begin
            case (aw_idx_q)
                IDX_OPA: opa_d = merge_bytes(opa_q, w_data_q, w_strb_q);
                IDX_OPB: opb_d = merge_bytes(opb_q, w_data_q, w_strb_q);
                IDX_CTRL: begin
                    if (w_strb_q[0]) begin
                        op_d = w_data_q[2:0];
                    end else begin
                        op_d = op_q;
                    end
                    if (w_strb_q[1]) begin
                        irq_en_d = w_data_q[9];
                    end else begin
                        irq_en_d = irq_en_q;
                    end
                end
                default: begin
                    opa_d = opa_q;
                end
            endcase
        end else begin
            opa_d = opa_q;
        end

        // The opcode travelling with START is the one that runs.
        if (eng_load_s) begin
            done_d    = 1'b0;
            err_d     = 1'b0;
            overrun_d = 1'b0;
            snap_a_d  = opa_q;
            snap_b_d  = opb_q;
            snap_op_d = op_d;
            prod_d    = {{DW{1'b0}}, opb_q};
            cnt_d     = {CW{1'b0}};
        end else if (wr_start_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        if (eng_busy_s && !eng_fin_s && (snap_op_q == OP_MUL)) begin
            prod_d = prod_step_s;
            cnt_d  = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_d;
        end

        if (res_we_s) begin
            res_lo_d = alu_lo_s;
            res_hi_d = alu_hi_s;
            err_d    = alu_err_s;
        end else begin
            res_lo_d = res_lo_q;
        end

        if (eng_fin_s) begin
            done_d = 1'b1;
        end else begin
            done_d = done_d;
        end
    end

    assign irq_d = done_d & irq_en_d;

    // Read data selection
    always_comb begin
        rd_val_s = {DW{1'b0}};
        case (ar_idx_s)
            IDX_OPA: rd_val_s = opa_q;
            IDX_OPB: rd_val_s = opb_q;
            IDX_CTRL: begin
                rd_val_s[2:0] = op_q;
                rd_val_s[9]   = irq_en_q;
            end
            IDX_STATUS: begin
                rd_val_s[0] = eng_busy_s;
                rd_val_s[1] = done_q;
                rd_val_s[2] = err_q;
                rd_val_s[3] = overrun_q;
            end
            IDX_RES_LO: rd_val_s = res_lo_q;
            IDX_RES_HI: rd_val_s = res_hi_q;
            default:    rd_val_s = {DW{1'b0}};
        endcase
    end

    // Read channel response
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val_s;
            rresp_d  = (ar_idx_s > IDX_RES_HI) ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Host interface, register file and engine datapath flops
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= 3'd0;
            w_held_q  <= 1'b0;
            w_data_q  <= {DW{1'b0}};
            w_strb_q  <= {NB{1'b0}};
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DW{1'b0}};
            rresp_q   <= 2'b00;
            opa_q     <= {DW{1'b0}};
            opb_q     <= {DW{1'b0}};
            op_q      <= 3'd0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            res_lo_q  <= {DW{1'b0}};
            res_hi_q  <= {DW{1'b0}};
            irq_q     <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            snap_a_q  <= {DW{1'b0}};
            snap_b_q  <= {DW{1'b0}};
            snap_op_q <= 3'd0;
            prod_q    <= {(2*DW){1'b0}};
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            irq_q     <= irq_d;
            cnt_q     <= cnt_d;
            snap_a_q  <= snap_a_d;
            snap_b_q  <= snap_b_d;
            snap_op_q <= snap_op_d;
            prod_q    <= prod_d;
        end
    end

endmodule

// File: tb/tb_calc_axil_core.sv
// -----------------------------------------------------------------------------
// tb_calc_axil_core
//
// Self-checking bench for calc_axil_core (32-bit data, 5-bit address).
// Directed scenarios cover reset state, each operation class, byte strobes,
// unmapped addresses, decoupled AW/W timing, overrun and reset mid-operation;
// a randomized loop then drives operands/opcodes against a behavioural model
// that computes results with plain wide arithmetic.
// -----------------------------------------------------------------------------
module tb_calc_axil_core;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        IRQ;

    calc_axil_core #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .IRQ(IRQ)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the register file
    logic [31:0] m_opa, m_opb, m_lo, m_hi;
    logic [2:0]  m_op;
    logic        m_irq_en, m_done, m_err, m_ovr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_opa = 32'd0; m_opb = 32'd0; m_lo = 32'd0; m_hi = 32'd0;
        m_op = 3'd0; m_irq_en = 1'b0; m_done = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    endtask

    function automatic logic [31:0] m_status();
        return {28'd0, m_ovr, m_err, m_done, 1'b0};
    endfunction

    function automatic logic [31:0] m_ctrl();
        return {22'd0, m_irq_en, 1'b0, 5'd0, m_op};
    endfunction

    // Apply a host write to the model; engine_busy says whether a run is in flight.
    task automatic model_write(input logic [2:0] idx, input logic [31:0] data,
                               input logic [3:0] strb, input bit engine_busy);
        logic [63:0] wide;
        for (int i = 0; i < 4; i++) begin
            if (strb[i] && idx == 3'd0) m_opa[8*i +: 8] = data[8*i +: 8];
            if (strb[i] && idx == 3'd1) m_opb[8*i +: 8] = data[8*i +: 8];
        end
        if (idx == 3'd2) begin
            if (strb[0]) m_op = data[2:0];
            if (strb[1]) m_irq_en = data[9];
            if (strb[1] && data[8]) begin
                if (engine_busy) begin
                    m_ovr = 1'b1;
                end else begin
                    m_ovr = 1'b0; m_err = 1'b0; m_done = 1'b1;
                    wide = 64'd0; m_lo = 32'd0; m_hi = 32'd0;
                    case (m_op)
                        3'd0: begin wide = {32'd0, m_opa} + {32'd0, m_opb}; m_lo = wide[31:0]; m_hi = wide[63:32]; end
                        3'd1: begin m_lo = m_opa - m_opb; m_hi = (m_opa < m_opb) ? 32'd1 : 32'd0; end
                        3'd2: begin wide = {32'd0, m_opa} * {32'd0, m_opb}; m_lo = wide[31:0]; m_hi = wide[63:32]; end
                        3'd3: m_lo = m_opa & m_opb;
                        3'd4: m_lo = m_opa | m_opb;
                        3'd5: m_lo = m_opa ^ m_opb;
                        default: m_err = 1'b1;
                    endcase
                end
            end
        end
    endtask

    // AXI write; W is presented w_delay cycles after AW.
    task automatic wr(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] strb,
                      input int w_delay, output logic [1:0] resp);
        int  cyc;
        bit  aw_done, w_done;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        @(negedge ACLK);
        S_AXI_AWADDR = {idx, 2'b00};
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            S_AXI_AWVALID = !aw_done;
            S_AXI_WVALID  = !w_done && (cyc >= w_delay);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
            @(negedge ACLK);
            cyc++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("wr_handshake", {31'd0, aw_done && w_done}, 32'd1);
        S_AXI_BREADY = 1'b1;
        cyc = 0;
        while (!S_AXI_BVALID && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        chk("bvalid_seen", {31'd0, S_AXI_BVALID}, 32'd1);
        resp = S_AXI_BRESP;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        bit acc;
        acc = 1'b0; cyc = 0;
        @(negedge ACLK);
        S_AXI_ARADDR  = {idx, 2'b00};
        S_AXI_ARVALID = 1'b1;
        while (!acc && cyc < 20) begin
            if (S_AXI_ARREADY) acc = 1'b1;
            @(negedge ACLK);
            cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        cyc = 0;
        while (!S_AXI_RVALID && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        chk("rvalid_seen", {31'd0, S_AXI_RVALID}, 32'd1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
    endtask

    // Poll STATUS until done appears or the read budget runs out.
    task automatic wait_done(input int max_reads, output logic [31:0] st);
        logic [1:0] r;
        st = 32'd0;
        for (int i = 0; i < max_reads; i++) begin
            rd(3'd3, st, r);
            if (st[1]) break;
        end
        chk("done_within_budget", {31'd0, st[1]}, 32'd1);
    endtask

    // Program operands and CTRL, wait for completion and check everything.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [3:0] a_strb,
                          input logic [31:0] b, input logic [31:0] ctrl, input int max_reads);
        logic [1:0]  r;
        logic [31:0] v;
        wr(3'd0, a, a_strb, 0, r);       model_write(3'd0, a, a_strb, 1'b0);
        wr(3'd1, b, 4'hF, 0, r);         model_write(3'd1, b, 4'hF, 1'b0);
        wr(3'd2, ctrl, 4'hF, 0, r);      model_write(3'd2, ctrl, 4'hF, 1'b0);
        chk({tag, "_bresp"}, {30'd0, r}, 32'd0);
        wait_done(max_reads, v);
        chk({tag, "_status"}, v, m_status());
        rd(3'd4, v, r); chk({tag, "_lo"}, v, m_lo);
        rd(3'd5, v, r); chk({tag, "_hi"}, v, m_hi);
        rd(3'd0, v, r); chk({tag, "_opa"}, v, m_opa);
        rd(3'd2, v, r); chk({tag, "_ctrl"}, v, m_ctrl());
        chk({tag, "_irq"}, {31'd0, IRQ}, {31'd0, m_done & m_irq_en});
    endtask

    initial begin
        logic [31:0] v;
        logic [1:0]  r;
        int          cnt;
        logic [31:0] a, b;
        logic [3:0]  s;

        ARESET = 1'b1;
        S_AXI_AWADDR = 5'd0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'd0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = 5'd0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        model_reset();
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;

        // Reset state
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        chk("rst_ready", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);
        for (int i = 0; i < 6; i++) begin
            rd(3'(i), v, r);
            chk("rst_rdata", v, 32'd0);
            chk("rst_rresp", {30'd0, r}, 32'd0);
        end

        // Basic add, carry out, subtract with borrow
        run_op("add7p5", 32'd7, 4'hF, 32'd5, 32'h100, 3);
        chk("add7p5_lo_const", m_lo, 32'd12);
        run_op("add_carry", 32'hFFFF_FFFF, 4'hF, 32'd1, 32'h100, 3);
        run_op("sub_borrow", 32'd3, 4'hF, 32'd5, 32'h101, 3);

        // Multiply with irq enabled: busy observed right after start
        wr(3'd0, 32'hFFFF_FFFF, 4'hF, 0, r); model_write(3'd0, 32'hFFFF_FFFF, 4'hF, 1'b0);
        wr(3'd1, 32'd2, 4'hF, 0, r);         model_write(3'd1, 32'd2, 4'hF, 1'b0);
        wr(3'd2, 32'h302, 4'hF, 0, r);       model_write(3'd2, 32'h302, 4'hF, 1'b0);
        rd(3'd3, v, r);
        chk("mul_busy", v, 32'h1);
        wait_done(40, v);
        chk("mul_status", v, m_status());
        rd(3'd4, v, r); chk("mul_lo", v, 32'hFFFF_FFFE);
        rd(3'd5, v, r); chk("mul_hi", v, 32'h1);
        chk("mul_irq", {31'd0, IRQ}, 32'd1);

        // Overrun: operand and START writes during a multiply
        wr(3'd2, 32'h302, 4'hF, 0, r);       model_write(3'd2, 32'h302, 4'hF, 1'b0);
        wr(3'd0, 32'd9, 4'hF, 0, r);         model_write(3'd0, 32'd9, 4'hF, 1'b1);
        wr(3'd2, 32'h100, 4'hF, 0, r);       model_write(3'd2, 32'h100, 4'hF, 1'b1);
        rd(3'd3, v, r);
        chk("ovr_flag", {31'd0, v[3]}, 32'd1);
        wait_done(40, v);
        chk("ovr_status", v, m_status());
        rd(3'd4, v, r); chk("ovr_lo", v, 32'hFFFF_FFFE);
        rd(3'd5, v, r); chk("ovr_hi", v, 32'h1);
        rd(3'd0, v, r); chk("ovr_opa", v, 32'd9);
        rd(3'd2, v, r); chk("ovr_ctrl", v, m_ctrl());
        chk("ovr_irq", {31'd0, IRQ}, 32'd0);

        // Byte strobes
        wr(3'd0, 32'h1122_3344, 4'hF, 0, r); model_write(3'd0, 32'h1122_3344, 4'hF, 1'b0);
        wr(3'd0, 32'hAABB_CCDD, 4'h1, 0, r); model_write(3'd0, 32'hAABB_CCDD, 4'h1, 1'b0);
        rd(3'd0, v, r); chk("strb_opa", v, 32'h1122_33DD);

        // Unmapped and read-only addresses
        wr(3'd7, 32'hDEAD_BEEF, 4'hF, 0, r); chk("wr7_bresp", {30'd0, r}, 32'd2);
        rd(3'd7, v, r); chk("rd7_rresp", {30'd0, r}, 32'd2); chk("rd7_rdata", v, 32'd0);
        wr(3'd6, 32'h1234_5678, 4'hF, 0, r); chk("wr6_bresp", {30'd0, r}, 32'd2);
        rd(3'd6, v, r); chk("rd6_rresp", {30'd0, r}, 32'd2); chk("rd6_rdata", v, 32'd0);
        wr(3'd4, 32'h5555_5555, 4'hF, 0, r); chk("wr_ro_bresp", {30'd0, r}, 32'd0);
        rd(3'd4, v, r); chk("ro_lo_kept", v, m_lo);
        wr(3'd3, 32'hF, 4'hF, 0, r);
        rd(3'd3, v, r); chk("ro_status_kept", v, m_status());

        // AW well ahead of W gives exactly one response
        wr(3'd1, 32'hCAFE_F00D, 4'hF, 3, r); model_write(3'd1, 32'hCAFE_F00D, 4'hF, 1'b0);
        cnt = 0;
        S_AXI_BREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) cnt++;
        end
        S_AXI_BREADY = 1'b0;
        chk("aw_early_single_b", 32'(cnt), 32'd0);
        rd(3'd1, v, r); chk("aw_early_opb", v, 32'hCAFE_F00D);

        // Illegal opcode
        run_op("illegal6", 32'h1234, 4'hF, 32'h5678, 32'h306, 3);
        chk("illegal6_err", {31'd0, m_err}, 32'd1);

        // Randomized operations
        for (int it = 0; it < 40; it++) begin
            a = $urandom();
            b = $urandom();
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF;
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd0;
            s = 4'($urandom_range(0, 15));
            run_op("rand", a, s, b,
                   {22'd0, 1'($urandom_range(0, 1)), 1'b1, 5'd0, 3'($urandom_range(0, 7))}, 40);
        end

        // Reset in the middle of a multiply with a read response pending
        wr(3'd0, 32'hFFFF_FFFF, 4'hF, 0, r);
        wr(3'd1, 32'd3, 4'hF, 0, r);
        wr(3'd2, 32'h302, 4'hF, 0, r);
        @(negedge ACLK);
        S_AXI_ARADDR = {3'd3, 2'b00};
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        repeat (5) @(negedge ACLK);
        chk("pre_rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        chk("pre_rst_rdata_busy", {31'd0, S_AXI_RDATA[0]}, 32'd1);
        #2 ARESET = 1'b1;
        #1;
        chk("async_rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("async_rst_ready", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID || S_AXI_BVALID) cnt++;
        end
        chk("post_rst_no_resp", 32'(cnt), 32'd0);
        chk("post_rst_irq", {31'd0, IRQ}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            rd(3'(i), v, r);
            chk("post_rst_reg", v, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
